// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB first.
// Computes d = a - b - bin (mod 2^WIDTH) and the borrow-out over WIDTH
// shift cycles, then presents the result with a one-cycle done pulse.
// Optional macro SERIAL_SUB_OVF_EN adds a signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             borrow;
    // Result register holds the WIDTH-1 bits already produced; the bit
    // computed on the final shift completes it, so no stale bit is kept.
    logic [WIDTH-2:0] sr;
    logic [CW-1:0]    cnt;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    logic             dbit;
    logic             nborrow;
    logic [WIDTH-1:0] res;

    // One full-subtractor step on the current LSBs plus the shifted result
    always_comb begin
        dbit    = ra[0] ^ rb[0] ^ borrow;
        nborrow = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & borrow);
        res     = {dbit, sr};
    end

    // Control FSM, datapath shift registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            borrow <= 1'b0;
            sr     <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            d      <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        ra     <= a;
                        rb     <= b;
                        borrow <= bin;
                        cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end else begin
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                SHIFT: begin
                    ra     <= ra >> 1;
                    rb     <= rb >> 1;
                    borrow <= nborrow;
                    sr     <= res[WIDTH-1:1];
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        d     <= res;
                        bout  <= nborrow;
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= (a_msb != b_msb) && (dbit != a_msb);
`endif
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int fails  = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic fail(input string tag, input int obs, input int exp);
    fails++;
    $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tbin, input logic [W-1:0] ed,
                        input logic eb, input string tag);
    int n;
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      a = W'($urandom_range(0, 15));
      b = W'($urandom_range(0, 15));
      bin = 1'($urandom_range(0, 1));
      tick();
      n++;
      if (!done) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
    end
    start = 1'b0;
    checks++; if (n !== 4) fail({tag, " latency"}, n, 4);
    checks++; if (d !== ed) fail({tag, " d"}, d, ed);
    checks++; if (bout !== eb) fail({tag, " bout"}, bout, eb);
  endtask

  initial begin
    int n;
    logic [W-1:0] ed;
    logic eb;
    int diff;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick();
    tick();
    checks++; if (busy !== 1'b0) fail("reset busy", busy, 0);
    checks++; if (done !== 1'b0) fail("reset done", done, 0);
    checks++; if (d !== 4'd0) fail("reset d", d, 0);
    checks++; if (bout !== 1'b0) fail("reset bout", bout, 0);
    rst_n = 1'b1;

    run_op(4'd7, 4'd3, 1'b0, 4'd4, 1'b0, "7-3");
    checks++; if (busy !== 1'b1) fail("7-3 busy in done", busy, 1);
    tick();
    checks++; if (done !== 1'b0) fail("7-3 done single", done, 0);
    checks++; if (busy !== 1'b0) fail("7-3 busy idle", busy, 0);
    checks++; if (d !== 4'd4) fail("7-3 d hold", d, 4);

    run_op(4'd3, 4'd7, 1'b0, 4'd12, 1'b1, "3-7");
    tick();
    run_op(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, "0-0-1");
    tick();

    a = 4'd7; b = 4'd3; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    checks++; if (n !== 4) fail("b2b first latency", n, 4);
    checks++; if (d !== 4'd4) fail("b2b first d", d, 4);
    a = 4'd9; b = 4'd9; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (done !== 1'b0) fail("b2b done dropped", done, 0);
    checks++; if (busy !== 1'b1) fail("b2b busy kept", busy, 1);
    checks++; if (d !== 4'd4) fail("b2b d held in shift", d, 4);
    n = 1;
    while (!done && n < 20) begin tick(); n++; end
    checks++; if (n !== 5) fail("b2b second spacing", n, 5);
    checks++; if (d !== 4'd0) fail("b2b second d", d, 0);
    checks++; if (bout !== 1'b0) fail("b2b second bout", bout, 0);
    tick();

    run_op(4'd3, 4'd7, 1'b0, 4'd12, 1'b1, "pre-reset");
    tick();
    a = 4'd7; b = 4'd3; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) fail("async rst busy", busy, 0);
    checks++; if (done !== 1'b0) fail("async rst done", done, 0);
    checks++; if (d !== 4'd0) fail("async rst d", d, 0);
    checks++; if (bout !== 1'b0) fail("async rst bout", bout, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) n++;
    end
    checks++; if (n !== 0) fail("rst no done pulse", n, 0);
    rst_n = 1'b1;
    run_op(4'd10, 4'd4, 1'b1, 4'd5, 1'b0, "after reset");
    tick();

`ifdef SERIAL_SUB_OVF_EN
    run_op(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, "ovf 8-1");
    checks++; if (ovf !== 1'b1) fail("ovf 8-1 ovf", ovf, 1);
    tick();
    checks++; if (ovf !== 1'b1) fail("ovf hold", ovf, 1);
    run_op(4'd5, 4'd2, 1'b0, 4'd3, 1'b0, "ovf 5-2");
    checks++; if (ovf !== 1'b0) fail("ovf 5-2 ovf", ovf, 0);
    tick();
`endif

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          diff = ia - ib - ic;
          ed = W'(diff & 15);
          eb = (diff < 0);
          run_op(W'(ia), W'(ib), 1'(ic), ed, eb, "sweep");
        end
      end
    end
    tick();
    checks++; if (busy !== 1'b0) fail("final idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, sampled on an accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, sampled on an accepted start.
REQ-007 The block SHALL have port bin, input, 1 bit: borrow-in, sampled on an accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse when the result becomes valid.
REQ-010 The block SHALL have port d, output, WIDTH bits: difference a - b - bin, modulo 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1 bit: borrow-out, high when a < b + bin (unsigned).

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1, the block SHALL latch a, b and bin (bin into the borrow register), clear the bit counter, and enter SHIFT; in IDLE with start=0, it SHALL remain in IDLE.
REQ-014 In SHIFT, each cycle the block SHALL process one bit, LSB first.
- Difference bit: a0 ^ b0 ^ borrow.
- Next borrow: (~a0 & b0) | (~(a0 ^ b0) & borrow).
- The difference bit SHALL shift into the result register from the MSB end.
- The operand registers SHALL shift right by one.
- The counter SHALL increment.
REQ-015 After exactly WIDTH SHIFT cycles, the block SHALL enter DONE.
- d SHALL take the completed result register.
- bout SHALL take the final borrow.
REQ-016 busy SHALL be high in SHIFT and DONE, and low in IDLE.
REQ-017 done SHALL be high only in DONE, for exactly one cycle.
REQ-018 Latency: for start accepted at rising edge T, done SHALL be high in the cycle following edge T+WIDTH, i.e. WIDTH+1 cycles after acceptance.
REQ-019 d and bout SHALL update only when entering DONE, and SHALL hold their values until the next completion or reset.
REQ-020 start SHALL be ignored while in SHIFT; operand inputs SHALL have no effect on an operation already in progress.
REQ-021 In DONE with start=1, the block SHALL accept the new operands and go directly to SHIFT (back-to-back operation); otherwise it SHALL return to IDLE.
REQ-022 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap within an operation.

Reset
REQ-023 When rst_n=0, the block SHALL immediately, independent of clk:
- enter IDLE;
- clear all internal registers;
- drive busy=0, done=0, d=0 and bout=0.
REQ-024 Reset asserted mid-operation SHALL abort it with no done pulse.
REQ-025 The first start SHALL be accepted on the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 With macro SERIAL_SUB_OVF_EN defined:
- the block SHALL add output port ovf, 1 bit;
- ovf SHALL be updated together with d, as (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]), using the latched original operands;
- ovf SHALL reset to 0 and hold like d.
REQ-027 Without SERIAL_SUB_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=4)
REQ-028 a=7, b=3, bin=0, start for one cycle -> done exactly 5 cycles later, d=4, bout=0.
REQ-029 a=3, b=7, bin=0 -> d=12, bout=1; a=0, b=0, bin=1 -> d=15, bout=1.
REQ-030 Back-to-back: start held high in DONE with a=9, b=9 -> second done exactly 5 cycles after the first, d=0, bout=0; start pulses during SHIFT leave results unchanged.
REQ-031 rst_n pulsed low at cycle 2 of SHIFT -> busy, done, d and bout go to 0 at once, with no done pulse; the next operation runs correctly.
REQ-032 With SERIAL_SUB_OVF_EN: a=8, b=1, bin=0 -> d=7, ovf=1, bout=0; a=5, b=2 -> d=3, ovf=0.
REQ-033 Exhaustive sweep of all a, b, bin -> d and bout equal the reference a - b - bin for every case.
